// File: rtl/result_readback.sv
// Result-path receive FIFO: captures controller result words into a circular RAM and presents
// them through a show-ahead valid/ready port. Optional feature macro: RESULT_TIMESTAMP_EN.
module result_readback #(
    parameter int unsigned RESULT_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2   = 6,
    parameter int unsigned DROP_WIDTH   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    init,
    input  logic [RESULT_WIDTH-1:0] result_data,
    input  logic                    result_wr_en,
    output logic [RESULT_WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DEPTH_LOG2+1:0]   level,
    output logic                    empty,
    output logic                    overflow,
    input  logic                    clear_overflow,
    output logic [DROP_WIDTH-1:0]   dropped
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
`ifdef RESULT_TIMESTAMP_EN
    localparam int unsigned StampWidth = 32;
    localparam int unsigned EntryWidth = RESULT_WIDTH + StampWidth;
`else
    localparam int unsigned EntryWidth = RESULT_WIDTH;
`endif

    typedef logic [DEPTH_LOG2:0]   ptr_t;
    typedef logic [DEPTH_LOG2-1:0] idx_t;
    typedef logic [DEPTH_LOG2+1:0] lvl_t;
    typedef logic [DROP_WIDTH-1:0] drop_t;

`ifdef RESULT_TIMESTAMP_EN
    typedef enum logic [1:0] {StIdle, StData, StStamp} state_e;
`else
    typedef enum logic [0:0] {StIdle, StData} state_e;
`endif

    state_e                  state_q, state_d;
    ptr_t                    wp_q, wp_d;
    ptr_t                    rp_q, rp_d;
    ptr_t                    ram_count, ram_count_d;
    logic [RESULT_WIDTH-1:0] rd_data_q, rd_data_d;
    lvl_t                    level_q, level_d;
    logic                    empty_q, empty_d;
    logic                    overflow_q, overflow_d;
    drop_t                   dropped_q, dropped_d;
    drop_t                   dropped_base;

    logic                    ram_full;
    logic                    ram_nonempty;
    logic                    do_write;
    logic                    do_drop;
    idx_t                    rd_idx;
    logic [EntryWidth-1:0]   wr_entry;
    logic [EntryWidth-1:0]   rd_entry;
    logic [EntryWidth-1:0]   mem_q [Depth];

`ifdef RESULT_TIMESTAMP_EN
    logic [StampWidth-1:0]   cycle_q;
    logic [EntryWidth-1:0]   next_entry;
`endif

    // Fullness uses the pre-edge count, so a pop on the same edge never rescues a write.
    assign ram_count    = wp_q - rp_q;
    assign ram_full     = ram_count[DEPTH_LOG2];
    assign ram_nonempty = (ram_count != '0);
    assign do_write     = result_wr_en & ~ram_full & ~init;
    assign do_drop      = result_wr_en & ram_full & ~init;
    assign rd_idx       = rp_q[DEPTH_LOG2-1:0];
    assign rd_entry     = mem_q[rd_idx];

`ifdef RESULT_TIMESTAMP_EN
    assign wr_entry   = {cycle_q, result_data};
    assign next_entry = mem_q[rd_idx + idx_t'(1)];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
        end else if (init) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + StampWidth'(1);
        end
    end
`else
    assign wr_entry = result_data;
`endif

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem_q[wp_q[DEPTH_LOG2-1:0]] <= wr_entry;
        end
    end

    always_comb begin
        wp_d = wp_q + ptr_t'(do_write);
        if (init) begin
            wp_d = '0;
        end
    end

    // Output stage: the presented word lives in rd_data_q; the RAM feeds it show-ahead.
    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        rp_d      = rp_q;
`ifdef RESULT_TIMESTAMP_EN
        // The entry stays in RAM (rp held) until its stamp is accepted.
        case (state_q)
            StIdle: begin
                if (ram_nonempty) begin
                    rd_data_d = rd_entry[RESULT_WIDTH-1:0];
                    state_d   = StData;
                end
            end
            StData: begin
                if (rd_ready) begin
                    rd_data_d = rd_entry[RESULT_WIDTH +: StampWidth];
                    state_d   = StStamp;
                end
            end
            StStamp: begin
                if (rd_ready) begin
                    rp_d = rp_q + ptr_t'(1);
                    if (ram_count > ptr_t'(1)) begin
                        rd_data_d = next_entry[RESULT_WIDTH-1:0];
                        state_d   = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
`else
        case (state_q)
            StIdle: begin
                if (ram_nonempty) begin
                    rd_data_d = rd_entry;
                    rp_d      = rp_q + ptr_t'(1);
                    state_d   = StData;
                end
            end
            StData: begin
                if (rd_ready) begin
                    if (ram_nonempty) begin
                        rd_data_d = rd_entry;
                        rp_d      = rp_q + ptr_t'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
`endif
        if (init) begin
            state_d   = StIdle;
            rd_data_d = '0;
            rp_d      = '0;
        end
    end

    always_comb begin
        ram_count_d = wp_d - rp_d;
`ifdef RESULT_TIMESTAMP_EN
        level_d = lvl_t'(ram_count_d);
`else
        level_d = lvl_t'(ram_count_d) + lvl_t'(state_d != StIdle);
`endif
        empty_d = (level_d == '0);
    end

    // Clear-then-increment: a drop on the clearing edge leaves overflow set and dropped at 1.
    always_comb begin
        dropped_base = clear_overflow ? '0 : dropped_q;
        overflow_d   = do_drop | (overflow_q & ~clear_overflow);
        dropped_d    = dropped_base;
        if (do_drop && (dropped_base != '1)) begin
            dropped_d = dropped_base + drop_t'(1);
        end
        if (init) begin
            overflow_d = 1'b0;
            dropped_d  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wp_q       <= '0;
            rp_q       <= '0;
            rd_data_q  <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            rd_data_q  <= rd_data_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = (state_q != StIdle);
    assign level    = level_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_result_readback.sv
// Bench for result_readback (default build): accepted words are queued as they are written
// and compared against rd_data at every output handshake.
module tb_result_readback;

    localparam int unsigned W  = 32;
    localparam int unsigned DL = 6;
    localparam int unsigned DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          init;
    logic [W-1:0]  result_data;
    logic          result_wr_en;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DL+1:0] level;
    logic          empty;
    logic          overflow;
    logic          clear_overflow;
    logic [DW-1:0] dropped;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;

    result_readback #(
        .RESULT_WIDTH (W),
        .DEPTH_LOG2   (DL),
        .DROP_WIDTH   (DW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .init           (init),
        .result_data    (result_data),
        .result_wr_en   (result_wr_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .level          (level),
        .empty          (empty),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .dropped        (dropped)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b0; result_wr_en = 1'b0; rd_ready = 1'b0;
        clear_overflow = 1'b0; result_data = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (dropped !== '0) begin errors++; $display("FAIL reset_dropped: got %0d want 0", dropped); end
    endtask

    task automatic test_single();
        result_data = 32'hDEAD_BEEF; result_wr_en = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        result_wr_en = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_latency_early: rd_valid %b want 0", rd_valid); end
        tick();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_latency: rd_valid %b want 1", rd_valid); end
        checks++; if (level !== 8'd1) begin errors++; $display("FAIL single_level: got %0d want 1", level); end
        rd_ready = 1'b1;
        exp_w = exp_q.pop_front();
        checks++; if (rd_data !== exp_w) begin errors++; $display("FAIL single_data: got %h want %h", rd_data, exp_w); end
        tick();
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_after_valid: got %b want 0", rd_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", empty); end
        checks++; if (level !== '0) begin errors++; $display("FAIL single_level_after: got %0d want 0", level); end
    endtask

    task automatic test_fill_drain();
        rd_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            result_data = W'(i); result_wr_en = 1'b1;
            exp_q.push_back(W'(i));
            tick();
        end
        result_wr_en = 1'b0;
        checks++; if (level !== 8'd64) begin errors++; $display("FAIL fill_level: got %0d want 64", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow: got %b want 0", overflow); end
        rd_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (rd_valid !== 1'b1) begin
                errors++; $display("FAIL drain_bubble[%0d]: rd_valid %b want 1", i, rd_valid);
            end else begin
                exp_w = exp_q.pop_front();
                if (rd_data !== exp_w) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, rd_data, exp_w); end
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
        checks++; if (level !== '0) begin errors++; $display("FAIL drain_level: got %0d want 0", level); end
        exp_q.delete();
    endtask

    task automatic test_overflow();
        rd_ready = 1'b0;
        for (int i = 0; i < 65; i++) begin
            result_data = 32'h100 + W'(i); result_wr_en = 1'b1;
            exp_q.push_back(32'h100 + W'(i));
            tick();
        end
        checks++; if (level !== 8'd65) begin errors++; $display("FAIL ovf_peak_level: got %0d want 65", level); end
        for (int i = 0; i < 3; i++) begin
            result_data = 32'hBAD0_0000 + W'(i); result_wr_en = 1'b1;
            tick();
        end
        result_wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        checks++; if (dropped !== 16'd3) begin errors++; $display("FAIL ovf_dropped: got %0d want 3", dropped); end
        checks++; if (level !== 8'd65) begin errors++; $display("FAIL ovf_level: got %0d want 65", level); end
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear_flag: got %b want 0", overflow); end
        checks++; if (dropped !== '0) begin errors++; $display("FAIL ovf_clear_dropped: got %0d want 0", dropped); end
        rd_ready = 1'b1;
        for (int i = 0; i < 65; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL ovf_drain_valid[%0d]: rd_valid %b want 1", i, rd_valid);
            end else begin
                exp_w = exp_q.pop_front();
                if (rd_data !== exp_w) begin errors++; $display("FAIL ovf_drain_data[%0d]: got %h want %h", i, rd_data, exp_w); end
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty: got %b want 1", empty); end
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        rd_ready = 1'b0;
        for (int i = 0; i < 65; i++) begin
            result_data = 32'h200 + W'(i); result_wr_en = 1'b1;
            exp_q.push_back(32'h200 + W'(i));
            tick();
        end
        // Full RAM: pop and write on the same edge, the write must be dropped.
        result_data = 32'hBAD1_0000; result_wr_en = 1'b1; rd_ready = 1'b1;
        exp_w = exp_q.pop_front();
        checks++; if (rd_data !== exp_w) begin errors++; $display("FAIL simul_pop_data: got %h want %h", rd_data, exp_w); end
        tick();
        result_wr_en = 1'b0; rd_ready = 1'b0;
        checks++; if (dropped !== 16'd1) begin errors++; $display("FAIL simul_dropped: got %0d want 1", dropped); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL simul_overflow: got %b want 1", overflow); end
        checks++; if (level !== 8'd64) begin errors++; $display("FAIL simul_level: got %0d want 64", level); end
        result_data = 32'h300; result_wr_en = 1'b1;
        exp_q.push_back(32'h300);
        tick();
        checks++; if (level !== 8'd65) begin errors++; $display("FAIL simul_refill_level: got %0d want 65", level); end
        // Clear and drop on one edge: drop wins, counter restarts at 1.
        result_data = 32'hBAD2_0000; clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_drop_overflow: got %b want 1", overflow); end
        checks++; if (dropped !== 16'd1) begin errors++; $display("FAIL clr_drop_dropped: got %0d want 1", dropped); end
        repeat (32'hFFFF + 5) tick();
        result_wr_en = 1'b0;
        checks++; if (dropped !== 16'hFFFF) begin errors++; $display("FAIL sat_dropped: got %h want ffff", dropped); end
        checks++; if (level !== 8'd65) begin errors++; $display("FAIL sat_level: got %0d want 65", level); end
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 65; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL simul_drain_valid[%0d]: rd_valid %b want 1", i, rd_valid);
            end else begin
                exp_w = exp_q.pop_front();
                if (rd_data !== exp_w) begin errors++; $display("FAIL simul_drain_data[%0d]: got %h want %h", i, rd_data, exp_w); end
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_drain_empty: got %b want 1", empty); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic want_valid;
        rd_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            want_valid = (i >= 2) && (i <= 21);
            checks++;
            if (rd_valid !== want_valid) begin
                errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, rd_valid, want_valid);
            end else if (rd_valid) begin
                exp_w = exp_q.pop_front();
                if (rd_data !== exp_w) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rd_data, exp_w); end
            end
            if (i < 20) begin
                result_data = 32'hA000 + W'(i); result_wr_en = 1'b1;
                exp_q.push_back(32'hA000 + W'(i));
            end else begin
                result_wr_en = 1'b0;
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_init();
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            result_data = 32'hC000 + W'(i); result_wr_en = 1'b1;
            exp_q.push_back(32'hC000 + W'(i));
            tick();
        end
        result_wr_en = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_w = exp_q.pop_front();
            checks++; if (rd_data !== exp_w) begin errors++; $display("FAIL init_pre_data[%0d]: got %h want %h", i, rd_data, exp_w); end
            tick();
        end
        init = 1'b1; result_wr_en = 1'b1; result_data = 32'h5555_5555; rd_ready = 1'b0;
        tick();
        init = 1'b0; result_wr_en = 1'b0;
        exp_q.delete();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL init_rd_valid: got %b want 0", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL init_rd_data: got %h want 0", rd_data); end
        checks++; if (level !== '0) begin errors++; $display("FAIL init_level: got %0d want 0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL init_empty: got %b want 1", empty); end
        repeat (3) tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL init_discard: rd_valid %b want 0", rd_valid); end
        result_data = 32'h1234; result_wr_en = 1'b1;
        exp_q.push_back(32'h1234);
        tick();
        result_wr_en = 1'b0;
        tick();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL init_after_valid: got %b want 1", rd_valid); end
        rd_ready = 1'b1;
        exp_w = exp_q.pop_front();
        checks++; if (rd_data !== exp_w) begin errors++; $display("FAIL init_after_data: got %h want %h", rd_data, exp_w); end
        tick();
        rd_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL init_after_empty: got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        test_simultaneous();
        test_back_to_back();
        test_init();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
